// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch pipeline types and constants
package fetch_unit_pkg;

  localparam int PC_W = 32;

  typedef logic [31:0] instr_t;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - program counter with redirect / sequential / hold next-PC mux
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM with holding register
// Optional FETCH_PERF_EN adds fetch_count / redirect_count outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  instr_t          imem_rdata,
  output instr_t          instr_out,
  output logic [PC_W-1:0] PC_out,
  output logic            valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     redirect_count
`endif
);

  logic [1:0]      state_q, state_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic            stale_q, stale_d;
  logic            valid_q, valid_d;
  instr_t          hold_q, hold_d;
  instr_t          instr_q, instr_d;
  instr_t          present_word;
  logic            present;
  logic [PC_W-1:0] pc;

  pc_reg #(
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc_reg (
    .clock        (clock),
    .reset        (reset),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .advance_i    (present),
    .pc_o         (pc)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = 1'b0;
    addr_d       = addr_q;
    stale_d      = stale_q;
    hold_d       = hold_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = 1'b0;
    present      = 1'b0;
    present_word = imem_rdata;
    case (state_q)
      ST_FETCH: begin
        if (!redirect && !stall) begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          // A response coinciding with the redirect is dropped now; otherwise it is still in flight.
          stale_d = !imem_rvalid;
          if (imem_rvalid) state_d = ST_FETCH;
        end else if (imem_rvalid) begin
          if (stale_q) begin
            stale_d = 1'b0;
            state_d = ST_FETCH;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            present = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_FETCH;
        end else if (!stall) begin
          present      = 1'b1;
          present_word = hold_q;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    if (present) begin
      instr_d  = present_word;
      pc_out_d = addr_q;
      valid_d  = 1'b1;
      state_d  = ST_FETCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      req_q    <= 1'b0;
      addr_q   <= '0;
      stale_q  <= 1'b0;
      hold_q   <= '0;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      stale_q  <= stale_d;
      hold_q   <= hold_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instr_out = instr_q;
  assign PC_out    = pc_out_q;
  assign valid_out = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, redirect_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q    <= '0;
      redirect_count_q <= '0;
    end else begin
      if (valid_d)  fetch_count_q    <= fetch_count_q + 32'd1;
      if (redirect) redirect_count_q <= redirect_count_q + 32'd1;
    end
  end

  assign fetch_count    = fetch_count_q;
  assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset, stall, redirect, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, instr_out, PC_out;

  logic        w_req, w_valid, w_rvalid;
  logic [31:0] w_addr, w_instr, w_pc, w_rdata;
  logic        no_stall = 1'b0;
  logic        no_redir = 1'b0;
  logic [31:0] no_target = 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, redirect_count, w_fetch_count, w_redirect_count;
  logic [31:0] w_fc2 = 32'h0;
`endif

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .PC_out(PC_out), .valid_out(valid_out)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clock(clock), .reset(reset), .stall(no_stall), .redirect(no_redir), .redirect_pc(no_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instr_out(w_instr), .PC_out(w_pc), .valid_out(w_valid)
`ifdef FETCH_PERF_EN
    , .fetch_count(w_fetch_count), .redirect_count(w_redirect_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Model: expected next instruction address, plus a one-slot memory with programmable latency.
  int          nvalid = 0;
  int          lat_cfg = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic        gate_ok = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc = 32'h0;

  always @(clock) begin
    if (clock) begin
      gate_ok = !stall && !redirect && !reset;
      if (reset) exp_pc = 32'h0;
      else if (redirect) exp_pc = redirect_pc;
    end else begin
      if (reset) exp_pc = 32'h0;
      if (valid_out) begin
        check("valid_gate", {31'b0, gate_ok}, 32'd1);
        check("valid_pc", PC_out, exp_pc);
        check("valid_instr", instr_out, mem_word(PC_out));
        exp_pc = exp_pc + 32'd1;
        nvalid++;
      end
      if (imem_req) begin
        check("req_gate", {31'b0, gate_ok}, 32'd1);
        check("req_single", {31'b0, pend}, 32'd0);
        check("req_addr", imem_addr, exp_pc);
      end
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end
      end
      if (imem_req) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        cnt       = (lat_cfg == 0) ? int'($urandom_range(3, 1)) : lat_cfg;
      end
    end
  end

  int          w_n = 0;
  logic        w_pend = 1'b0;
  logic [31:0] w_paddr = 32'h0;
  logic [31:0] w_pc1 = 32'h0;
  logic [31:0] w_pc2 = 32'h0;

  always @(negedge clock) begin
    w_rvalid = w_pend;
    w_rdata  = mem_word(w_paddr);
    w_pend   = w_req;
    w_paddr  = w_addr;
    if (w_valid) begin
      w_n++;
      if (w_n == 1) w_pc1 = w_pc;
      if (w_n == 2) begin
        w_pc2 = w_pc;
`ifdef FETCH_PERF_EN
        w_fc2 = w_fetch_count;
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_valid();
    int n0 = nvalid;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (nvalid > n0) return;
    end
    check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (imem_req) return;
    end
    check("req_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_pc", PC_out, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wait_valid();
      check("seq_pc", PC_out, i);
      check("seq_instr", instr_out, mem_word(i));
    end
    check("wrap_pc1", w_pc1, 32'hFFFF_FFFF);
    check("wrap_pc2", w_pc2, 32'h0);
`ifdef FETCH_PERF_EN
    check("wrap_fetch_count", w_fc2, 32'd2);
`endif

    wait_req();
    n0 = nvalid;
    stall = 1'b1;
    repeat (3) tick();
    check("stall_hold_valid", {31'b0, valid_out}, 32'd0);
    check("stall_hold_count", nvalid, n0);
    stall = 1'b0;
    tick();
    check("stall_release", nvalid, n0 + 1);
    tick();
    check("stall_once", nvalid, n0 + 1);

    lat_cfg = 3;
    redirect = 1'b1; redirect_pc = 32'h5;
    tick();
    redirect = 1'b0;
    wait_req();
    check("redir_setup", imem_addr, 32'h5);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    wait_valid();
    check("redir_pc", PC_out, 32'h40);
    check("redir_instr", instr_out, mem_word(32'h40));

    lat_cfg = 1;
    wait_req();
    tick();
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h80;
    tick();
    check("rsr_valid", {31'b0, valid_out}, 32'd0);
    redirect = 1'b0; stall = 1'b0;
    wait_req();
    check("rsr_target", imem_addr, 32'h80);
    lat_cfg = 3;

    wait_req();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_valid", {31'b0, valid_out}, 32'd0);
    check("async_req", {31'b0, imem_req}, 32'd0);
    check("async_pc", PC_out, 32'h0);
    check("async_instr", instr_out, 32'h0);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    tick();
    check("refetch_req", {31'b0, imem_req}, 32'd1);
    check("refetch_addr", imem_addr, 32'h0);
    wait_valid();
    check("refetch_pc", PC_out, 32'h0);

    lat_cfg = 0;
    for (int c = 0; c < 1500; c++) begin
      stall    = ($urandom_range(3, 0) == 0);
      redirect = ($urandom_range(15, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
      tick();
    end
    stall = 1'b0; redirect = 1'b0;
    repeat (3) wait_valid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
